// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter for the write side of a single fifo.
// A requester gets a grant only if the fifo can absorb a full burst.
// The burst ends on the requester's last beat, after MAX_BURST beats,
// or when the requester stays silent for IDLE_TIMEOUT cycles (0 = never).
module fifo_wr_arb #(
    parameter int NREQ         = 4,
    parameter int DATA_WIDTH   = 72,
    parameter int ADDR_WIDTH   = 9,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]              req_last,
    output logic [NREQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]        fifo_din,
    output logic                         fifo_wr_en,
    input  logic                         fifo_full,
    input  logic [ADDR_WIDTH-1:0]        fifo_elemcnt,
    output logic [NREQ-1:0]              grant,
    output logic                         abort
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [ADDR_WIDTH:0] CAPACITY   = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] BURST_ROOM = (ADDR_WIDTH + 1)'(MAX_BURST);
    localparam logic [BW-1:0]       BEAT_LAST  = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0]       IDLE_LAST  = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [BW-1:0]   beat_cnt;
    logic [IW-1:0]   idle_cnt;

    logic [ADDR_WIDTH:0] free_space;
    logic                eligible;
    logic [PW-1:0]       pick;
    logic [PW-1:0]       cand;
    logic                found;
    logic                own_valid;
    logic                own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                beat;
    logic                burst_end;
    logic                timeout;

    // Free space never goes negative: elemcnt is at most 2^ADDR_WIDTH-1.
    assign free_space = CAPACITY - {1'b0, fifo_elemcnt};
    assign eligible   = (|req_valid) && (free_space >= BURST_ROOM);

    // Rotating priority: first valid requester strictly after rr_ptr.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Select the current owner's beat signals; rr_ptr holds the owner during a burst.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rr_ptr == PW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign beat      = (state == BURST) && own_valid && !fifo_full;
    assign burst_end = beat && (own_last || (beat_cnt == BEAT_LAST));
    assign timeout   = (IDLE_TIMEOUT != 0) && (state == BURST) && !beat && (idle_cnt == IDLE_LAST);

    // Combinational write path to the fifo; quiet outside a burst.
    always_comb begin
        req_ready  = '0;
        fifo_din   = '0;
        fifo_wr_en = 1'b0;
        if (state == BURST) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rr_ptr == PW'(i)) begin
                    req_ready[i] = !fifo_full;
                end
            end
            fifo_din   = own_data;
            fifo_wr_en = beat;
        end
    end

    // Arbitration FSM with registered grant and abort.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= PW'(NREQ - 1);
            beat_cnt <= '0;
            idle_cnt <= '0;
            abort    <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (eligible) begin
                        grant    <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                        rr_ptr   <= pick;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        idle_cnt <= '0;
                        if (burst_end) begin
                            grant <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        if (idle_cnt != {IW{1'b1}}) begin
                            idle_cnt <= idle_cnt + IW'(1);
                        end
                        // rr_ptr is left on the aborted requester so it ranks last next round.
                        if (timeout) begin
                            grant <= '0;
                            abort <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: two instances (MAX_BURST 16 and 4, both
// IDLE_TIMEOUT 8) share the producers; each has its own fifo occupancy model.
module tb_fifo_wr_arb;
    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 9;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;

    logic [NREQ-1:0] rdy16, rdy4, g16, g4;
    logic [DW-1:0]   din16, din4;
    logic            wr16, wr4, ab16, ab4;

    int cnt16, cnt4;
    logic [AW-1:0] ec16, ec4;
    logic full16, full4;
    assign ec16   = cnt16[AW-1:0];
    assign ec4    = cnt4[AW-1:0];
    assign full16 = (cnt16 >= 511);
    assign full4  = (cnt4 >= 511);

    int pend [NREQ];
    int plen [NREQ];
    int seq  [NREQ];
    bit use4;
    bit rd16;

    logic [NREQ-1:0] s_g16, s_g4, s_rdy16;
    logic [DW-1:0]   s_din16;
    logic            s_wr16, s_wr4, s_ab16, s_ab4;

    int checks = 0;
    int errors = 0;

    fifo_wr_arb #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(16), .IDLE_TIMEOUT(8)) dut16 (
        .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(rdy16), .fifo_din(din16), .fifo_wr_en(wr16), .fifo_full(full16),
        .fifo_elemcnt(ec16), .grant(g16), .abort(ab16));

    fifo_wr_arb #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(4), .IDLE_TIMEOUT(8)) dut4 (
        .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(rdy4), .fifo_din(din4), .fifo_wr_en(wr4), .fifo_full(full4),
        .fifo_elemcnt(ec4), .grant(g4), .abort(ab4));

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (pend[i] > 0);
            req_last[i]  = (plen[i] != 0) && ((seq[i] % plen[i]) == plen[i] - 1);
            req_data[i*DW +: DW] = DW'((i << 12) | (seq[i] & 'hfff));
        end
    endtask

    // One clock: sample at negedge, then advance producers and fifo models after posedge.
    task automatic cycle();
        logic [NREQ-1:0] fire;
        @(negedge clk);
        s_g16 = g16; s_g4 = g4; s_rdy16 = rdy16; s_din16 = din16;
        s_wr16 = wr16; s_wr4 = wr4; s_ab16 = ab16; s_ab4 = ab4;
        fire = req_valid & (use4 ? rdy4 : rdy16);
        @(posedge clk); #1;
        cnt16 = cnt16 + (s_wr16 ? 1 : 0) - ((rd16 && cnt16 > 0) ? 1 : 0);
        cnt4  = cnt4 + (s_wr4 ? 1 : 0);
        for (int i = 0; i < NREQ; i++) begin
            if (fire[i]) begin
                pend[i] = pend[i] - 1;
                seq[i]  = seq[i] + 1;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; plen[i] = 0; seq[i] = 0;
        end
        drive();
        cnt16 = 0; cnt4 = 0; rd16 = 1'b0; use4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); clr_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1; plen[i] = 1; seq[i] = 0;
        end
        drive();
        repeat (3) @(posedge clk); #1;
        checks++; if (g16 !== 4'b0)   begin errors++; $display("FAIL reset_grant16 got=%b exp=0000", g16); end
        checks++; if (g4 !== 4'b0)    begin errors++; $display("FAIL reset_grant4 got=%b exp=0000", g4); end
        checks++; if (rdy16 !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", rdy16); end
        checks++; if (wr16 !== 1'b0)  begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr16); end
        checks++; if (din16 !== '0)   begin errors++; $display("FAIL reset_din got=%h exp=0000", din16); end
        checks++; if (ab16 !== 1'b0)  begin errors++; $display("FAIL reset_abort got=%b exp=0", ab16); end
        @(negedge clk); clr_n = 1'b1;
        @(negedge clk);
        checks++; if (g16 !== 4'b0001) begin errors++; $display("FAIL reset_first_winner got=%b exp=0001", g16); end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] eg;
        pend[1] = 5; plen[1] = 5; drive();
        for (int c = 0; c < 8; c++) begin
            cycle();
            eg = (c >= 1 && c <= 5) ? 4'b0010 : 4'b0000;
            checks++; if (s_g16 !== eg) begin errors++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, s_g16, eg); end
            checks++; if (s_wr16 !== (eg != 0)) begin errors++; $display("FAIL single_wr_en c=%0d got=%b exp=%b", c, s_wr16, (eg != 0)); end
            checks++; if (s_rdy16 !== eg) begin errors++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, s_rdy16, eg); end
            if (c >= 1 && c <= 5) begin
                checks++;
                if (s_din16 !== DW'(16'h1000 + c - 1)) begin
                    errors++; $display("FAIL single_din c=%0d got=%h exp=%h", c, s_din16, DW'(16'h1000 + c - 1));
                end
            end
        end
        checks++; if (cnt16 != 5) begin errors++; $display("FAIL single_elemcnt got=%0d exp=5", cnt16); end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] eg;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 100; plen[i] = 3;
        end
        drive();
        for (int c = 0; c < 20; c++) begin
            cycle();
            eg = (c % 4 == 0) ? 4'b0000 : 4'(1 << ((c / 4) % 4));
            checks++; if (s_g16 !== eg) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, s_g16, eg); end
            checks++; if (s_wr16 !== (eg != 0)) begin errors++; $display("FAIL rr_wr_en c=%0d got=%b exp=%b", c, s_wr16, (eg != 0)); end
            checks++; if (s_rdy16 !== eg) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, s_rdy16, eg); end
        end
    endtask

    task automatic test_burst_cap();
        int eg [28] = '{0,1,1,0,4,4,4,4,0,1,1,0,4,4,4,4,0,4,4,4,4,4,4,4,4,4,4,0};
        use4 = 1'b1;
        pend[2] = 10; plen[2] = 0;
        pend[0] = 4;  plen[0] = 2;
        drive();
        for (int c = 0; c < 28; c++) begin
            cycle();
            checks++; if (s_g4 !== 4'(eg[c])) begin errors++; $display("FAIL cap_grant c=%0d got=%b exp=%b", c, s_g4, 4'(eg[c])); end
            checks++; if (s_wr4 !== (eg[c] != 0 && c < 19)) begin errors++; $display("FAIL cap_wr_en c=%0d got=%b exp=%b", c, s_wr4, (eg[c] != 0 && c < 19)); end
            checks++; if (s_ab4 !== (c == 27)) begin errors++; $display("FAIL cap_abort c=%0d got=%b exp=%b", c, s_ab4, (c == 27)); end
        end
    endtask

    task automatic test_space_gating();
        logic [NREQ-1:0] eg;
        cnt16 = 500;
        pend[3] = 3; plen[3] = 3; drive();
        for (int c = 0; c < 11; c++) begin
            rd16 = (c >= 4 && c <= 8);
            cycle();
            eg = (c == 10) ? 4'b1000 : 4'b0000;
            checks++; if (s_g16 !== eg) begin errors++; $display("FAIL space_grant c=%0d got=%b exp=%b", c, s_g16, eg); end
        end
        rd16 = 1'b0;
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] eg;
        pend[0] = 2; plen[0] = 0;
        pend[1] = 1; plen[1] = 1;
        drive();
        for (int c = 0; c < 14; c++) begin
            cycle();
            eg = (c >= 1 && c <= 10) ? 4'b0001 : (c == 12) ? 4'b0010 : 4'b0000;
            checks++; if (s_g16 !== eg) begin errors++; $display("FAIL timeout_grant c=%0d got=%b exp=%b", c, s_g16, eg); end
            checks++; if (s_ab16 !== (c == 11)) begin errors++; $display("FAIL timeout_abort c=%0d got=%b exp=%b", c, s_ab16, (c == 11)); end
            checks++; if (s_wr16 !== (c == 1 || c == 2 || c == 12)) begin errors++; $display("FAIL timeout_wr_en c=%0d got=%b exp=%b", c, s_wr16, (c == 1 || c == 2 || c == 12)); end
        end
    endtask

    task automatic test_timeout_beat();
        logic [NREQ-1:0] eg;
        pend[0] = 2; plen[0] = 0; drive();
        for (int c = 0; c < 20; c++) begin
            if (c == 10) begin
                pend[0] = 1; drive();
            end
            cycle();
            eg = (c >= 1 && c <= 18) ? 4'b0001 : 4'b0000;
            checks++; if (s_g16 !== eg) begin errors++; $display("FAIL tbeat_grant c=%0d got=%b exp=%b", c, s_g16, eg); end
            checks++; if (s_ab16 !== (c == 19)) begin errors++; $display("FAIL tbeat_abort c=%0d got=%b exp=%b", c, s_ab16, (c == 19)); end
            checks++; if (s_wr16 !== (c == 1 || c == 2 || c == 10)) begin errors++; $display("FAIL tbeat_wr_en c=%0d got=%b exp=%b", c, s_wr16, (c == 1 || c == 2 || c == 10)); end
        end
    endtask

    task automatic test_reset_mid();
        pend[0] = 10; plen[0] = 0; drive();
        for (int c = 0; c < 3; c++) cycle();
        checks++; if (s_g16 !== 4'b0001) begin errors++; $display("FAIL mid_started got=%b exp=0001", s_g16); end
        @(negedge clk);
        checks++; if (wr16 !== 1'b1) begin errors++; $display("FAIL mid_beat3 got=%b exp=1", wr16); end
        clr_n = 1'b0;
        #1;
        checks++; if (g16 !== 4'b0)   begin errors++; $display("FAIL mid_grant got=%b exp=0000", g16); end
        checks++; if (rdy16 !== 4'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0000", rdy16); end
        checks++; if (wr16 !== 1'b0)  begin errors++; $display("FAIL mid_wr_en got=%b exp=0", wr16); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        pend[1] = 4; plen[1] = 4; drive();
        @(negedge clk);
        checks++; if (g16 !== 4'b0001) begin errors++; $display("FAIL mid_first_winner got=%b exp=0001", g16); end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; plen[i] = 0; seq[i] = 0;
        end
        cnt16 = 0; cnt4 = 0; rd16 = 1'b0; use4 = 1'b0;
        drive();
        test_reset();
        do_reset(); test_single();
        do_reset(); test_round_robin();
        do_reset(); test_burst_cap();
        do_reset(); test_space_gating();
        do_reset(); test_timeout();
        do_reset(); test_timeout_beat();
        do_reset(); test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
